affine_accum: RTL and testbench

Downstream consumer of the sequential signed multiplier in the affine datapath. It collects NTERMS full-width products for one output coordinate (e.g. a·x and b·y) and adds an integer translation. It then rounds away the FRAC fractional bits and saturates the sum to WIDTH bits. The result is presented on a valid/ready output port to the coordinate writeback logic.

---
 rtl/affinex_pkg.sv | 49 ++++
 rtl/affine_accum_if.sv | 30 +++
 rtl/affine_accum_round_sat.sv | 32 +++
 rtl/affine_accum.sv | 114 +++++++++++
 tb/tb_affine_accum.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/affinex_pkg.sv
// Purpose : shared types and helpers for the affine datapath stages.
// Latency : n/a (types, constants, combinational helpers only).
// Backpr. : n/a.
// Contents: accumulator FSM state enum, accumulator width helper, saturate-to-width helper.
package affinex_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACC   = 2'd1,
      ROUND = 2'd2,
      OUT   = 2'd3
   } state_e;

   // Two product-width terms plus 3 guard bits: sums of up to 4 products
   // plus the shifted offset never wrap.
   function automatic int accw(input int width);
      return 2 * width + 3;
   endfunction

   // Widest value the saturate helper accepts; callers sign-extend into it.
   localparam int SAT_MAXW = 64;

   typedef struct packed {
      logic                        sat;
      logic signed [SAT_MAXW-1:0]  val;
   } sat_res_t;

   // Clip a signed value to the signed range of 'width' bits (width >= 2).
   function automatic sat_res_t saturate(input logic signed [SAT_MAXW-1:0] v,
                                         input int                         width);
      logic signed [SAT_MAXW-1:0] hi;
      logic signed [SAT_MAXW-1:0] lo;
      sat_res_t                   res;
      hi = (64'sd1 <<< (width - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (width - 1));
      if (v > hi) begin
         res.sat = 1'b1;
         res.val = hi;
      end else if (v < lo) begin
         res.sat = 1'b1;
         res.val = lo;
      end else begin
         res.sat = 1'b0;
         res.val = v;
      end
      return res;
   endfunction

endpackage

// File: rtl/affine_accum_if.sv
// Purpose : job/term/result bundle between the multiplier side, the accumulator and writeback.
// Latency : n/a (wiring only).
// Backpr. : result side is valid/ready; term side has no backpressure (strobe only).
// Signals : start_i/offset_i (job start), term_valid_i/term_i (product strobe),
//           busy_o, out_valid_o/out_ready_i/out_o/sat_o (result handshake).
interface affine_accum_if #(
   parameter int WIDTH = 16
);
   logic                 start_i;
   logic [WIDTH-1:0]     offset_i;
   logic                 term_valid_i;
   logic [2*WIDTH-1:0]   term_i;
   logic                 busy_o;
   logic                 out_valid_o;
   logic                 out_ready_i;
   logic [WIDTH-1:0]     out_o;
   logic                 sat_o;

   // Accumulator side.
   modport slave (
      input  start_i, offset_i, term_valid_i, term_i, out_ready_i,
      output busy_o, out_valid_o, out_o, sat_o
   );

   // Job issuer / result consumer side.
   modport master (
      output start_i, offset_i, term_valid_i, term_i, out_ready_i,
      input  busy_o, out_valid_o, out_o, sat_o
   );
endinterface

// File: rtl/affine_accum_round_sat.sv
// Purpose : round-half-up an ACCW-bit fixed-point sum by FRAC bits and clip it to WIDTH bits.
// Latency : combinational.
// Backpr. : none.
// Ports   : acc_i (signed ACCW), out_o (signed WIDTH), sat_o (clip flag).
module round_sat
   import affinex_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int FRAC  = 8
) (
   input  logic [accw(WIDTH)-1:0] acc_i,
   output logic [WIDTH-1:0]       out_o,
   output logic                   sat_o
);
   localparam int ACCW = accw(WIDTH);
   // Half an LSB of the result; guarded so FRAC=0 never evaluates a negative shift.
   localparam longint HALF = (FRAC > 0) ? (64'sd1 <<< ((FRAC > 0) ? FRAC - 1 : 0)) : 64'sd0;

   logic signed [ACCW:0]          sum;
   logic signed [ACCW:0]          r;
   sat_res_t                      res;
   logic                          unused_hi;

   // One extra bit so adding the half-LSB can never wrap.
   assign sum = $signed({acc_i[ACCW-1], acc_i}) + $signed((ACCW+1)'(HALF));
   assign r   = sum >>> FRAC;
   assign res = saturate(SAT_MAXW'(r), WIDTH);

   assign out_o     = res.val[WIDTH-1:0];
   assign sat_o     = res.sat;
   assign unused_hi = ^res.val[SAT_MAXW-1:WIDTH];
endmodule

// File: rtl/affine_accum.sv
// Purpose : sum NTERMS signed products plus (offset <<< FRAC), round away FRAC bits, saturate to WIDTH.
// Latency : out_valid_o rises two cycles after the cycle carrying the last term strobe.
// Backpr. : result held stable while out_ready_i is low; terms arriving outside ACC are dropped.
// Ports   : clk_i, rst_n (async, active-low), bus (affine_accum_if.slave).
module affine_accum
   import affinex_pkg::*;
#(
   parameter int WIDTH  = 16,
   parameter int FRAC   = 8,
   parameter int NTERMS = 2
) (
   input  logic              clk_i,
   input  logic              rst_n,
   affine_accum_if.slave     bus
);
   localparam int ACCW = accw(WIDTH);
   localparam int CNTW = $clog2(NTERMS + 1);

   state_e               state_q, state_d;
   logic [ACCW-1:0]      acc_q, acc_d;
   logic [CNTW-1:0]      cnt_q, cnt_d;
   logic [WIDTH-1:0]     out_q, out_d;
   logic                 sat_q, sat_d;
   logic                 busy_q, busy_d;
   logic                 out_valid_q, out_valid_d;

   logic [ACCW-1:0]      acc_load;
   logic [ACCW-1:0]      acc_sum;
   logic [WIDTH-1:0]     rs_out;
   logic                 rs_sat;

   assign acc_load = ACCW'($signed(bus.offset_i)) <<< FRAC;
   assign acc_sum  = acc_q + ACCW'($signed(bus.term_i));

   round_sat #(
      .WIDTH (WIDTH),
      .FRAC  (FRAC)
   ) u_round_sat (
      .acc_i (acc_q),
      .out_o (rs_out),
      .sat_o (rs_sat)
   );

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      out_d   = out_q;
      sat_d   = sat_q;
      unique case (state_q)
         IDLE: begin
            if (bus.start_i) begin
               acc_d   = acc_load;
               cnt_d   = '0;
               state_d = ACC;
            end
         end
         ACC: begin
            if (bus.term_valid_i) begin
               acc_d = acc_sum;
               cnt_d = cnt_q + CNTW'(1);
               if (cnt_q == CNTW'(NTERMS - 1)) begin
                  state_d = ROUND;
               end
            end
         end
         ROUND: begin
            out_d   = rs_out;
            sat_d   = rs_sat;
            state_d = OUT;
         end
         OUT: begin
            if (bus.out_ready_i) begin
               state_d = IDLE;
               // Back-to-back: a start in the handshake cycle skips IDLE.
               if (bus.start_i) begin
                  acc_d   = acc_load;
                  cnt_d   = '0;
                  state_d = ACC;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      // Status flags decoded from the next state so they are registered outputs.
      busy_d      = (state_d == ACC) || (state_d == ROUND);
      out_valid_d = (state_d == OUT);
   end

   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         acc_q       <= '0;
         cnt_q       <= '0;
         out_q       <= '0;
         sat_q       <= 1'b0;
         busy_q      <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         out_q       <= out_d;
         sat_q       <= sat_d;
         busy_q      <= busy_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign bus.busy_o      = busy_q;
   assign bus.out_valid_o = out_valid_q;
   assign bus.out_o       = out_q;
   assign bus.sat_o       = sat_q;
endmodule

// File: tb/tb_affine_accum.sv
// Purpose : self-checking bench for affine_accum (WIDTH=16, FRAC=8, NTERMS=2) with a result scoreboard.
// Latency : drives on the falling edge, samples on the falling edge after each rising edge.
// Backpr. : exercises stalled results, back-to-back restart and ignored strobes.
module tb_affine_accum;
   import affinex_pkg::*;

   typedef struct packed {
      logic [15:0] o;
      logic        s;
   } exp_t;

   logic clk_i = 1'b0;
   logic rst_n = 1'b0;
   int   n_cmp = 0;
   int   n_bad = 0;
   exp_t sb[$];

   always #5 clk_i = ~clk_i;

   affine_accum_if #(.WIDTH(16)) bus ();

   affine_accum #(
      .WIDTH  (16),
      .FRAC   (8),
      .NTERMS (2)
   ) dut (
      .clk_i (clk_i),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Reference: integer arithmetic straight from the operation description.
   function automatic exp_t model(input logic signed [15:0] off,
                                  input logic signed [31:0] t0,
                                  input logic signed [31:0] t1);
      longint acc;
      longint r;
      exp_t   e;
      acc = longint'(off) * 256 + longint'(t0) + longint'(t1);
      r   = (acc + 128) >>> 8;
      if (r > 32767) begin
         e.o = 16'h7fff; e.s = 1'b1;
      end else if (r < -32768) begin
         e.o = 16'h8000; e.s = 1'b1;
      end else begin
         e.o = r[15:0];  e.s = 1'b0;
      end
      return e;
   endfunction

   // Apply one cycle of stimulus (called at a falling edge), return at the next falling edge.
   task automatic cyc(input logic st, input logic [15:0] off, input logic tv, input logic [31:0] t);
      bus.start_i      = st;
      bus.offset_i     = off;
      bus.term_valid_i = tv;
      bus.term_i       = t;
      @(negedge clk_i);
      bus.start_i      = 1'b0;
      bus.term_valid_i = 1'b0;
   endtask

   task automatic run_job(input logic [15:0] off, input logic [31:0] t0, input logic [31:0] t1);
      sb.push_back(model(off, t0, t1));
      cyc(1'b1, off, 1'b0, 32'd0);
      cyc(1'b0, 16'd0, 1'b1, t0);
      cyc(1'b0, 16'd0, 1'b1, t1);
   endtask

   task automatic collect(input string name);
      int   k;
      exp_t e;
      k = 0;
      while (!bus.out_valid_o && k < 20) begin
         @(negedge clk_i);
         k++;
      end
      n_cmp++;
      if (!bus.out_valid_o) begin
         n_bad++;
         $display("FAIL %s: out_valid_o timeout, got 0 expected 1", name);
         if (sb.size() > 0) e = sb.pop_front();
      end else begin
         e = sb.pop_front();
         n_cmp++;
         if (bus.out_o !== e.o || bus.sat_o !== e.s) begin
            n_bad++;
            $display("FAIL %s: out_o=%0d sat_o=%0b expected out_o=%0d sat_o=%0b",
                     name, $signed(bus.out_o), bus.sat_o, $signed(e.o), e.s);
         end
         bus.out_ready_i = 1'b1;
         @(negedge clk_i);
         bus.out_ready_i = 1'b0;
         n_cmp++;
         if (bus.out_valid_o !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_handshake: out_valid_o=%0b expected 0", name, bus.out_valid_o);
         end
      end
   endtask

   task automatic test_reset();
      bus.start_i = 1'b0; bus.offset_i = '0; bus.term_valid_i = 1'b0;
      bus.term_i = '0; bus.out_ready_i = 1'b0;
      #1;
      n_cmp++;
      if ({bus.out_o, bus.sat_o, bus.out_valid_o, bus.busy_o} !== 19'd0) begin
         n_bad++;
         $display("FAIL reset_outputs: out=%h sat=%b vld=%b busy=%b expected all 0",
                  bus.out_o, bus.sat_o, bus.out_valid_o, bus.busy_o);
      end
      repeat (2) @(negedge clk_i);
      rst_n = 1'b1;
      // Ready with nothing pending must not produce a result.
      bus.out_ready_i = 1'b1;
      repeat (3) @(negedge clk_i);
      bus.out_ready_i = 1'b0;
      n_cmp++;
      if (bus.out_valid_o !== 1'b0 || bus.busy_o !== 1'b0 || dut.state_q !== IDLE) begin
         n_bad++;
         $display("FAIL idle_ready: vld=%b busy=%b state=%0d expected 0 0 IDLE",
                  bus.out_valid_o, bus.busy_o, dut.state_q);
      end
   endtask

   task automatic test_basic();
      sb.push_back(model(16'd3, 32'h200, 32'h080));
      cyc(1'b1, 16'd3, 1'b0, 32'd0);
      n_cmp++;
      if (bus.busy_o !== 1'b1) begin
         n_bad++; $display("FAIL basic_busy_rise: busy_o=%b expected 1", bus.busy_o);
      end
      cyc(1'b0, 16'd0, 1'b1, 32'h200);
      cyc(1'b0, 16'd0, 1'b1, 32'h080);
      n_cmp++;
      if (bus.out_valid_o !== 1'b0 || bus.busy_o !== 1'b1) begin
         n_bad++; $display("FAIL basic_round_cycle: vld=%b busy=%b expected 0 1", bus.out_valid_o, bus.busy_o);
      end
      cyc(1'b0, 16'd0, 1'b0, 32'd0);
      n_cmp++;
      if (bus.out_valid_o !== 1'b1 || bus.busy_o !== 1'b0) begin
         n_bad++; $display("FAIL basic_latency: vld=%b busy=%b expected 1 0", bus.out_valid_o, bus.busy_o);
      end
      collect("basic");
   endtask

   task automatic test_rounding();
      run_job(16'd0, 32'd640, 32'd0);
      collect("round_pos");
      run_job(16'd0, -32'sd640, 32'd0);
      collect("round_neg");
   endtask

   task automatic test_saturation();
      run_job(16'd0, 32'h4000_0000, 32'h4000_0000);
      collect("sat_pos");
      run_job(16'd0, 32'hC000_0000, 32'hC000_0000);
      collect("sat_neg");
   endtask

   task automatic test_back_to_back();
      int   k;
      exp_t e;
      run_job(16'd0, 32'h100, 32'h100);
      k = 0;
      while (!bus.out_valid_o && k < 20) begin
         @(negedge clk_i);
         k++;
      end
      e = sb.pop_front();
      for (int i = 0; i < 5; i++) begin
         n_cmp++;
         if (bus.out_valid_o !== 1'b1 || bus.out_o !== e.o || bus.sat_o !== e.s) begin
            n_bad++;
            $display("FAIL stall_%0d: vld=%b out=%0d sat=%b expected 1 %0d %b",
                     i, bus.out_valid_o, $signed(bus.out_o), bus.sat_o, $signed(e.o), e.s);
         end
         cyc(1'b0, 16'd0, 1'b0, 32'd0);
      end
      sb.push_back(model(16'd1, 32'd0, 32'd0));
      bus.out_ready_i = 1'b1;
      cyc(1'b1, 16'd1, 1'b0, 32'd0);
      bus.out_ready_i = 1'b0;
      n_cmp++;
      if (bus.out_valid_o !== 1'b0 || bus.busy_o !== 1'b1 || dut.state_q !== ACC) begin
         n_bad++;
         $display("FAIL b2b_restart: vld=%b busy=%b state=%0d expected 0 1 ACC",
                  bus.out_valid_o, bus.busy_o, dut.state_q);
      end
      cyc(1'b0, 16'd0, 1'b1, 32'd0);
      cyc(1'b0, 16'd0, 1'b1, 32'd0);
      collect("b2b");
   endtask

   task automatic test_ignored();
      cyc(1'b0, 16'd0, 1'b1, 32'h7fff_0000);
      n_cmp++;
      if (bus.busy_o !== 1'b0 || bus.out_valid_o !== 1'b0) begin
         n_bad++; $display("FAIL idle_term: busy=%b vld=%b expected 0 0", bus.busy_o, bus.out_valid_o);
      end
      sb.push_back(model(16'd3, 32'h200, 32'h080));
      cyc(1'b1, 16'd3, 1'b0, 32'd0);
      cyc(1'b0, 16'd0, 1'b1, 32'h200);
      cyc(1'b1, 16'd100, 1'b0, 32'd0);
      cyc(1'b0, 16'd0, 1'b1, 32'h080);
      collect("ignored");
   endtask

   task automatic test_reset_mid();
      cyc(1'b1, 16'd5, 1'b0, 32'd0);
      cyc(1'b0, 16'd0, 1'b1, 32'h1234);
      #2 rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({bus.out_o, bus.sat_o, bus.out_valid_o, bus.busy_o} !== 19'd0 || dut.state_q !== IDLE) begin
         n_bad++;
         $display("FAIL reset_mid: out=%h sat=%b vld=%b busy=%b state=%0d expected 0 0 0 0 IDLE",
                  bus.out_o, bus.sat_o, bus.out_valid_o, bus.busy_o, dut.state_q);
      end
      @(negedge clk_i);
      rst_n = 1'b1;
      run_job(16'd3, 32'h200, 32'h080);
      collect("after_reset");
   endtask

   initial begin
      test_reset();
      test_basic();
      test_rounding();
      test_saturation();
      test_back_to_back();
      test_ignored();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
